// File: rtl/ones_scan_arbiter_if.sv
// Request/result bus between the requesters and ones_scan_arbiter.
// master = requester side, slave = arbiter side.
interface ones_scan_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(N_REQ);
  localparam int PW  = $clog2(WIDTH);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic                   done;
  logic [IDW-1:0]         done_id;
  logic                   found;
  logic [PW-1:0]          pos;

  modport master (output req, data, input gnt, busy, done, done_id, found, pos);
  modport slave  (input req, data, output gnt, busy, done, done_id, found, pos);
endinterface

// File: rtl/ones_scan_arbiter.sv
// Round-robin arbiter feeding one shared MSB-first serial first-one scanner.
// Optional macro ONES_SCAN_EARLY_EXIT_EN: finish the scan on the first '1' seen.
module ones_scan_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                reset,
  ones_scan_arbiter_if.slave bus
);
  localparam int IDW = $clog2(N_REQ);
  localparam int PW  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [PW-1:0]    idx;
  logic [PW-1:0]    pos_r;
  logic             found_r;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   last_winner;
  logic [IDW-1:0]   rr_pick;
  logic             rr_any;
  logic             msb;
  logic             hit;
  logic             last;

  // Search upward from last_winner+1; the first asserted requester wins.
  always_comb begin
    logic [31:0]    cand;
    logic [IDW-1:0] c;
    rr_pick = last_winner;
    rr_any  = 1'b0;
    cand    = '0;
    c       = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(last_winner) + 32'(k)) % 32'(N_REQ);
      c    = IDW'(cand);
      if (!rr_any && bus.req[c]) begin
        rr_any  = 1'b1;
        rr_pick = c;
      end
    end
  end

  assign msb = shreg[WIDTH-1];
  assign hit = msb && !found_r;
`ifdef ONES_SCAN_EARLY_EXIT_EN
  assign last = (idx == PW'(WIDTH-1)) || hit;
`else
  assign last = (idx == PW'(WIDTH-1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      idx         <= '0;
      pos_r       <= '0;
      found_r     <= 1'b0;
      winner      <= '0;
      last_winner <= IDW'(N_REQ-1);
      bus.gnt     <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.done_id <= '0;
      bus.found   <= 1'b0;
      bus.pos     <= '0;
    end else begin
      bus.gnt  <= '0;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (rr_any) begin
            shreg            <= bus.data[rr_pick*WIDTH +: WIDTH];
            bus.gnt[rr_pick] <= 1'b1;
            winner           <= rr_pick;
            last_winner      <= rr_pick;
            idx              <= '0;
            found_r          <= 1'b0;
            pos_r            <= '0;
            bus.busy         <= 1'b1;
            state            <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            found_r <= 1'b1;
            pos_r   <= idx;
          end
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          idx   <= idx + 1'b1;
          // Result regs see this edge's bit directly, since found_r/pos_r lag by one.
          if (last) begin
            state       <= DONE;
            bus.done    <= 1'b1;
            bus.done_id <= winner;
            bus.found   <= found_r | msb;
            bus.pos     <= hit ? idx : pos_r;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ones_scan_arbiter.sv
// Scoreboard bench for ones_scan_arbiter: expected results queued at stimulus time,
// popped and compared when done pulses.
module tb_ones_scan_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    logic [1:0] id;
    logic       found;
    logic [2:0] pos;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int compared = 0;
  int mismatched = 0;
  exp_t sb[$];

  ones_scan_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
  ones_scan_arbiter #(.N_REQ(N), .WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] id, input logic [W-1:0] w);
    exp_t e;
    e.id = id; e.found = 1'b0; e.pos = '0; e.lat = W;
    for (int i = 0; i < W; i++)
      if (!e.found && w[W-1-i]) begin
        e.found = 1'b1;
        e.pos = i[2:0];
      end
`ifdef ONES_SCAN_EARLY_EXIT_EN
    if (e.found) e.lat = int'(e.pos) + 1;
`endif
    return e;
  endfunction

  task automatic set_word(input int id, input logic [W-1:0] w);
    bus.data[id*W +: W] = w;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.req = '0; bus.data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_gnt(output logic [N-1:0] g, output int n);
    g = '0; n = 0;
    while (n < 40) begin
      @(negedge clk); n++;
      if (bus.gnt !== '0) begin g = bus.gnt; return; end
    end
    compared++; mismatched++;
    $display("FAIL gnt_timeout got=none exp=grant within 40 cycles");
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk); n++;
      if (bus.done === 1'b1) return;
    end
    compared++; mismatched++;
    $display("FAIL done_timeout got=none exp=done within 40 cycles");
  endtask

  task automatic test_reset();
    #2 reset = 1'b1; bus.req = '0; bus.data = '0;
    #1;
    compared++; if (bus.gnt !== '0) begin mismatched++; $display("FAIL rst_gnt got=%b exp=0", bus.gnt); end
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    compared++; if (bus.done !== 1'b0) begin mismatched++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    compared++; if (bus.done_id !== '0) begin mismatched++; $display("FAIL rst_done_id got=%0d exp=0", bus.done_id); end
    compared++; if (bus.found !== 1'b0) begin mismatched++; $display("FAIL rst_found got=%b exp=0", bus.found); end
    compared++; if (bus.pos !== '0) begin mismatched++; $display("FAIL rst_pos got=%0d exp=0", bus.pos); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [N-1:0] g; int n; exp_t e;
    set_word(0, 8'b0010_0000);
    @(negedge clk); bus.req = 4'b0001;
    wait_gnt(g, n); bus.req = '0;
    compared++; if (g !== 4'b0001) begin mismatched++; $display("FAIL single_gnt got=%b exp=0001", g); end
    compared++; if (n !== 1) begin mismatched++; $display("FAIL single_gnt_lat got=%0d exp=1", n); end
    compared++; if (bus.busy !== 1'b1) begin mismatched++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    sb.push_back(model(2'd0, 8'b0010_0000));
    wait_done(n);
    e = sb.pop_front();
    compared++; if (n !== e.lat) begin mismatched++; $display("FAIL single_done_lat got=%0d exp=%0d", n, e.lat); end
    compared++; if (bus.done_id !== e.id) begin mismatched++; $display("FAIL single_id got=%0d exp=%0d", bus.done_id, e.id); end
    compared++; if (bus.found !== e.found) begin mismatched++; $display("FAIL single_found got=%b exp=%b", bus.found, e.found); end
    compared++; if (bus.pos !== e.pos) begin mismatched++; $display("FAIL single_pos got=%0d exp=%0d", bus.pos, e.pos); end
    @(negedge clk);
    compared++; if ({bus.done, bus.busy} !== 2'b00) begin mismatched++; $display("FAIL single_idle got=%b exp=00", {bus.done, bus.busy}); end
  endtask

  task automatic test_zero();
    logic [N-1:0] g; int n; exp_t e;
    set_word(1, 8'h00);
    @(negedge clk); bus.req = 4'b0010;
    wait_gnt(g, n); bus.req = '0;
    compared++; if (g !== 4'b0010) begin mismatched++; $display("FAIL zero_gnt got=%b exp=0010", g); end
    sb.push_back(model(2'd1, 8'h00));
    wait_done(n);
    e = sb.pop_front();
    compared++; if (n !== e.lat) begin mismatched++; $display("FAIL zero_done_lat got=%0d exp=%0d", n, e.lat); end
    compared++; if (bus.done_id !== e.id) begin mismatched++; $display("FAIL zero_id got=%0d exp=%0d", bus.done_id, e.id); end
    compared++; if (bus.found !== e.found) begin mismatched++; $display("FAIL zero_found got=%b exp=%b", bus.found, e.found); end
    compared++; if (bus.pos !== e.pos) begin mismatched++; $display("FAIL zero_pos got=%0d exp=%0d", bus.pos, e.pos); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] g, eg; int n, prev_lat; exp_t e;
    logic [W-1:0] words [N];
    int order [5];
    words = '{8'h01, 8'h40, 8'h00, 8'h18};
    order = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) set_word(i, words[i]);
    bus.req = 4'b1111;
    prev_lat = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(g, n);
      eg = 4'b0001 << order[k];
      compared++; if (g !== eg) begin mismatched++; $display("FAIL b2b_gnt[%0d] got=%b exp=%b", k, g, eg); end
      if (k > 0) begin
        compared++;
        if (prev_lat + n !== prev_lat + 2) begin mismatched++; $display("FAIL b2b_gap[%0d] got=%0d exp=%0d", k, prev_lat + n, prev_lat + 2); end
`ifndef ONES_SCAN_EARLY_EXIT_EN
        compared++;
        if (prev_lat + n !== W + 2) begin mismatched++; $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", k, prev_lat + n, W + 2); end
`endif
      end
      sb.push_back(model(order[k][1:0], words[order[k]]));
      wait_done(n);
      e = sb.pop_front();
      prev_lat = n;
      if (k == 4) bus.req = '0;
      compared++; if (n !== e.lat) begin mismatched++; $display("FAIL b2b_lat[%0d] got=%0d exp=%0d", k, n, e.lat); end
      compared++; if (bus.done_id !== e.id) begin mismatched++; $display("FAIL b2b_id[%0d] got=%0d exp=%0d", k, bus.done_id, e.id); end
      compared++; if (bus.found !== e.found) begin mismatched++; $display("FAIL b2b_found[%0d] got=%b exp=%b", k, bus.found, e.found); end
      compared++; if (bus.pos !== e.pos) begin mismatched++; $display("FAIL b2b_pos[%0d] got=%0d exp=%0d", k, bus.pos, e.pos); end
    end
    @(negedge clk);
  endtask

  task automatic test_data_change();
    logic [N-1:0] g; int n; exp_t e;
    set_word(2, 8'b1000_0001);
    @(negedge clk); bus.req = 4'b0100;
    wait_gnt(g, n); bus.req = '0;
    set_word(2, 8'h00);
    compared++; if (g !== 4'b0100) begin mismatched++; $display("FAIL chg_gnt got=%b exp=0100", g); end
    sb.push_back(model(2'd2, 8'b1000_0001));
    wait_done(n);
    e = sb.pop_front();
    compared++; if (n !== e.lat) begin mismatched++; $display("FAIL chg_lat got=%0d exp=%0d", n, e.lat); end
    compared++; if (bus.done_id !== e.id) begin mismatched++; $display("FAIL chg_id got=%0d exp=%0d", bus.done_id, e.id); end
    compared++; if (bus.found !== e.found) begin mismatched++; $display("FAIL chg_found got=%b exp=%b", bus.found, e.found); end
    compared++; if (bus.pos !== e.pos) begin mismatched++; $display("FAIL chg_pos got=%0d exp=%0d", bus.pos, e.pos); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] g; int n, dones; exp_t e;
    @(negedge clk);
    set_word(0, 8'h01);
    bus.req = 4'b0001;
    wait_gnt(g, n); bus.req = '0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    compared++; if (bus.gnt !== '0) begin mismatched++; $display("FAIL mid_gnt got=%b exp=0", bus.gnt); end
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
    compared++; if (bus.done_id !== '0) begin mismatched++; $display("FAIL mid_done_id got=%0d exp=0", bus.done_id); end
    compared++; if (bus.found !== 1'b0) begin mismatched++; $display("FAIL mid_found got=%b exp=0", bus.found); end
    dones = 0;
    repeat (3) begin @(negedge clk); if (bus.done !== 1'b0) dones++; end
    compared++; if (dones !== 0) begin mismatched++; $display("FAIL mid_no_done got=%0d exp=0", dones); end
    reset = 1'b0;
    set_word(1, 8'h10);
    set_word(2, 8'h02);
    bus.req = 4'b0110;
    wait_gnt(g, n); bus.req = '0;
    compared++; if (g !== 4'b0010) begin mismatched++; $display("FAIL mid_regrant got=%b exp=0010", g); end
    sb.push_back(model(2'd1, 8'h10));
    wait_done(n);
    e = sb.pop_front();
    compared++; if (bus.done_id !== e.id) begin mismatched++; $display("FAIL mid_id got=%0d exp=%0d", bus.done_id, e.id); end
    compared++; if (bus.pos !== e.pos) begin mismatched++; $display("FAIL mid_pos got=%0d exp=%0d", bus.pos, e.pos); end
  endtask

  task automatic test_pulse_while_busy();
    logic [N-1:0] g; int n, gnts, dones; exp_t e;
    @(negedge clk);
    set_word(0, 8'h03);
    bus.req = 4'b0001;
    wait_gnt(g, n); bus.req = '0;
    compared++; if (g !== 4'b0001) begin mismatched++; $display("FAIL pulse_gnt got=%b exp=0001", g); end
    sb.push_back(model(2'd0, 8'h03));
    @(negedge clk); bus.req = 4'b1000;
    @(negedge clk); bus.req = '0;
    wait_done(n);
    e = sb.pop_front();
    compared++; if (n + 2 !== e.lat) begin mismatched++; $display("FAIL pulse_lat got=%0d exp=%0d", n + 2, e.lat); end
    compared++; if (bus.found !== e.found) begin mismatched++; $display("FAIL pulse_found got=%b exp=%b", bus.found, e.found); end
    compared++; if (bus.pos !== e.pos) begin mismatched++; $display("FAIL pulse_pos got=%0d exp=%0d", bus.pos, e.pos); end
    gnts = 0; dones = 0;
    repeat (2*W) begin
      @(negedge clk);
      if (bus.gnt !== '0) gnts++;
      if (bus.done !== 1'b0) dones++;
    end
    compared++; if (gnts !== 0) begin mismatched++; $display("FAIL pulse_extra_gnt got=%0d exp=0", gnts); end
    compared++; if (dones !== 0) begin mismatched++; $display("FAIL pulse_extra_done got=%0d exp=0", dones); end
  endtask

  initial begin
    bus.req = '0;
    bus.data = '0;
    test_reset();
    test_single();
    test_zero();
    test_back_to_back();
    test_data_change();
    test_reset_mid();
    test_pulse_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ones_scan_arbiter.md
# ones_scan_arbiter

Shared first-one scan engine with a round-robin front end. Up to N_REQ requesters each present a WIDTH-bit word; the block grants one at a time, captures the word, scans it serially MSB-first exactly as the serial first-one detector consumes a bit stream, and reports whether a '1' was found and at which bit position. It is the scheduler that lets several producers share one serial detector datapath instead of instantiating one per producer.

## Interface

- N_REQ, 4, number of requesters (>= 2)
- WIDTH, 8, bits per word (>= 2)
- IDW, $clog2(N_REQ), requester-id width (derived)
- PW, $clog2(WIDTH), position width (derived)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately
- req  in  N_REQ  per-requester request level; held until granted
- data  in  N_REQ*WIDTH  word of requester i on data[i*WIDTH +: WIDTH]
- gnt  out  N_REQ  one-hot, one-cycle pulse: word of that requester captured
- busy  out  1  high while a word is in SCAN or DONE
- done  out  1  one-cycle pulse: result valid
- done_id  out  IDW  requester whose result is reported
- found  out  1  word contained at least one '1'
- pos  out  PW  index of first '1', 0 = MSB; 0 when found=0

## Operation

- States: IDLE, SCAN, DONE. Reset -> IDLE.
- IDLE: if req != 0, pick winner by round-robin starting at last_winner+1 (wrapping); load shift register with winner's word, gnt[winner]<=1, idx<=0, found_r<=0, state<=SCAN. No req: stay.
- SCAN, each edge: examine shreg[WIDTH-1]; if 1 and found_r==0, found_r<=1, pos_r<=idx. Shift left by one, idx<=idx+1. Leave to DONE when idx==WIDTH-1 (last bit examined), or earlier per Configuration.
- DONE: done=1, done_id=winner, found/pos valid; next edge -> IDLE.
- found, pos, done_id are registered and update only on entry to DONE; they hold their values otherwise. Only first '1' is recorded; later '1's ignored.
- last_winner resets to N_REQ-1, so requester 0 has priority at first arbitration. Updated at every grant.
- req ignored outside IDLE; requester deasserting before grant gets no grant. A requester still asserting req after its gnt is treated as a fresh request.
- data sampled only at the grant edge; changes afterwards have no effect.

## Timing

- Reset values: gnt=0, busy=0, done=0, done_id=0, found=0, pos=0; state IDLE, last_winner=N_REQ-1.
- E0 = edge where IDLE sees req: gnt and busy high in cycle after E0; gnt low after E1.
- Full scan: bits examined at E1..E_WIDTH; done high for the cycle after E_WIDTH; E_WIDTH+1 returns to IDLE, busy and done low.
- Earliest next grant at E_WIDTH+2; throughput one word per WIDTH+2 cycles.
- Reset asserted mid-scan: aborts word, no done pulse, outputs to reset values asynchronously; arbitration restarts from requester 0.
- Simultaneous requests: exactly one gnt bit per grant; losers keep waiting.

## Configuration

- ONES_SCAN_EARLY_EXIT_EN defined: SCAN also leaves to DONE on the edge a '1' is first seen; first '1' at position p gives done in the cycle after E_(p+1). All-zero words still take the full WIDTH edges.
- Not defined: every word takes exactly WIDTH scan edges regardless of content; results identical, only latency differs.

## Test plan

- Reset then single req[0], data0=8'b0010_0000 -> gnt[0] pulse after E0; done after E8 (E3 with EARLY_EXIT), done_id=0, found=1, pos=2.
- data=8'h00 on req[1] -> found=0, pos=0, done after E8 in both builds.
- req=4'b1111 held continuously, distinct words -> grant order 0,1,2,3,0; each done_id matches; gnt spacing WIDTH+2 cycles (full scan).
- data2=8'b1000_0001 -> pos=0, found=1 (later '1' ignored); change data2 to 8'h00 one cycle after gnt -> result unchanged.
- Assert reset at E4 of a scan -> all outputs 0 immediately, no done; after release req=4'b0110 -> requester 1 granted first.
- req[3] pulsed for one cycle while busy -> no gnt[3], no extra done.
